// File: rtl/fir_pkg.sv
// Shared FIR helpers: default widths, accumulator sizing and the shift/round-half-up/clip function.
// Used by the tap accumulator and any later filter top that needs the same output scaling.
package fir_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int OUT_W_DEF  = 16;
  localparam int MAX_W      = 64;

  function automatic int acc_w(input int num_taps, input int prod_w);
    return prod_w + $clog2(num_taps);
  endfunction

  // Works one bit wider than the sum so a full-scale sum plus the rounding term cannot wrap.
  // Returns {sat, data}; callers keep the low out_w bits of data.
  function automatic logic [MAX_W:0] sat_round(input logic [MAX_W-1:0] total,
                                               input int shift,
                                               input int out_w);
    logic [MAX_W:0] r;
    logic [MAX_W:0] lim;
    r = {1'b0, total};
    if (shift > 0) r = r + ((MAX_W+1)'(1) << (shift - 1));
    r = r >> shift;
    lim = ((MAX_W+1)'(1) << out_w) - (MAX_W+1)'(1);
    if (r > lim) return {1'b1, lim[MAX_W-1:0]};
    return {1'b0, r[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational scale of the accumulated sum: shift right, round half up, saturate to OUT_W.
// Zero latency, no flow control.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = 35,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic [ACC_W-1:0] total,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  logic [MAX_W:0] res;
  logic           unused_hi;

  assign res       = sat_round(MAX_W'(total), SHIFT, OUT_W);
  assign data      = res[OUT_W-1:0];
  assign sat       = res[MAX_W];
  assign unused_hi = ^res[MAX_W-1:OUT_W];

endmodule

// File: rtl/fir_tap_accumulator.sv
// Sums NUM_TAPS serial tap products into one rounded, saturated sample; y_valid rises the cycle after the final tap.
// One-entry output register: only the final tap stalls while a sample is held and not taken.
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 8,
  parameter int PROD_W   = PROD_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int SHIFT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tap_valid,
  output logic                        tap_ready,
  input  logic [PROD_W-1:0]           tap_data,
  input  logic                        frame_clr,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [OUT_W-1:0]            y_data,
  output logic                        y_sat,
  output logic [$clog2(NUM_TAPS)-1:0] tap_idx
);

  localparam int ACC_W = acc_w(NUM_TAPS, PROD_W);
  localparam int IDX_W = $clog2(NUM_TAPS);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [OUT_W-1:0] rs_data;
  logic             rs_sat;
  logic             last_tap;
  logic             tap_fire;
  logic             y_fire;
  logic             load;

  assign last_tap  = (tap_idx == IDX_W'(NUM_TAPS - 1));
  assign tap_ready = !(last_tap && y_valid && !y_ready);
  assign tap_fire  = tap_valid && tap_ready;
  assign y_fire    = y_valid && y_ready;
  // A cleared frame drops its tap, so a final tap under frame_clr never produces a sample.
  assign load      = tap_fire && last_tap && !frame_clr;
  assign sum       = ((tap_idx == '0) ? '0 : acc) + ACC_W'(tap_data);

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .total (sum),
    .data  (rs_data),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      tap_idx <= '0;
    end else if (frame_clr || (tap_fire && last_tap)) begin
      acc     <= '0;
      tap_idx <= '0;
    end else if (tap_fire) begin
      acc     <= sum;
      tap_idx <= tap_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_sat   <= 1'b0;
    end else if (load) begin
      y_valid <= 1'b1;
      y_data  <= rs_data;
      y_sat   <= rs_sat;
    end else if (y_fire) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Bench for fir_tap_accumulator (NUM_TAPS=4, PROD_W=32, OUT_W=16, SHIFT=15) with an expected-sample queue.
module tb_fir_tap_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tap_valid = 1'b0;
  logic        tap_ready;
  logic [31:0] tap_data = '0;
  logic        frame_clr = 1'b0;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [15:0] y_data;
  logic        y_sat;
  logic [1:0]  tap_idx;

  int checks = 0;
  int errors = 0;

  logic [16:0]     exp_q[$];
  longint unsigned m_acc = 0;
  int              m_idx = 0;

  fir_tap_accumulator #(
    .NUM_TAPS (4),
    .PROD_W   (32),
    .OUT_W    (16),
    .SHIFT    (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .tap_data  (tap_data),
    .frame_clr (frame_clr),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y_data    (y_data),
    .y_sat     (y_sat),
    .tap_idx   (tap_idx)
  );

  always #5 clk = ~clk;

  // Reference model of one accepted tap; pushes {sat,data} on the fourth.
  task automatic model_accept(input logic [31:0] d);
    longint unsigned r;
    logic [15:0]     lo;
    m_acc = m_acc + longint'(d);
    if (m_idx == 3) begin
      r  = (m_acc + 64'd16384) >> 15;
      lo = r[15:0];
      if (r > 64'd65535) exp_q.push_back({1'b1, 16'hFFFF});
      else               exp_q.push_back({1'b0, lo});
      m_acc = 0;
      m_idx = 0;
    end else begin
      m_idx = m_idx + 1;
    end
  endtask

  task automatic send_tap(input logic [31:0] d);
    int n;
    n = 0;
    tap_valid = 1'b1;
    tap_data  = d;
    @(negedge clk);
    while (!tap_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tap_ready) begin
      checks++; errors++;
      $display("FAIL tap_accept_timeout: tap_ready=%b required 1", tap_ready);
    end
    model_accept(d);
    @(posedge clk); #1;
    tap_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] e);
    send_tap(a); send_tap(b); send_tap(c); send_tap(e);
  endtask

  // Output monitor: every output transfer is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: y_data=%h y_sat=%b with nothing expected", y_data, y_sat);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({y_sat, y_data} !== e) begin
          errors++;
          $display("FAIL sample: got sat=%b data=%h required sat=%b data=%h", y_sat, y_data, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; tap_valid = 1'b1; tap_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (y_valid !== 1'b0 || y_data !== 16'h0 || tap_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: y_valid=%b y_data=%h tap_idx=%0d required 0/0000/0", y_valid, y_data, tap_idx);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; tap_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tap_ready !== 1'b1 || y_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: tap_ready=%b y_sat=%b required 1/0", tap_ready, y_sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    y_ready = 1'b1;
    send_frame(32'h8000, 32'h8000, 32'h8000, 32'h8000);
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b1 || y_data !== 16'h0004 || y_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: y_valid=%b y_data=%h y_sat=%b required 1/0004/0", y_valid, y_data, y_sat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: y_valid=%b required 0", y_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    send_frame(32'h2000, 32'h2000, 32'h0, 32'h0);
    send_frame(32'h3FFF, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_frame(32'h7FFF_3FFF, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    y_ready = 1'b0;
    send_frame(32'h8000, 32'h8000, 32'h8000, 32'h8000);
    send_tap(32'h10000); send_tap(32'h10000); send_tap(32'h10000);
    tap_valid = 1'b1; tap_data = 32'h10000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (tap_ready !== 1'b0 || tap_idx !== 2'd3) begin
        errors++;
        $display("FAIL hold_stall: tap_ready=%b tap_idx=%0d required 0/3", tap_ready, tap_idx);
      end
      checks++;
      if (y_valid !== 1'b1 || y_data !== 16'h0004 || y_sat !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: y_valid=%b y_data=%h y_sat=%b required 1/0004/0", y_valid, y_data, y_sat);
      end
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tap_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: tap_ready=%b required 1", tap_ready);
    end
    model_accept(32'h10000);
    @(posedge clk); #1;
    tap_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b1 || y_data !== 16'h0008) begin
      errors++;
      $display("FAIL no_bubble: y_valid=%b y_data=%h required 1/0008", y_valid, y_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_clr();
    y_ready = 1'b1;
    send_tap(32'h0012_3456); send_tap(32'h0012_3456);
    frame_clr = 1'b1; tap_valid = 1'b1; tap_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    frame_clr = 1'b0; tap_valid = 1'b0;
    m_acc = 0; m_idx = 0;
    @(negedge clk);
    checks++;
    if (tap_idx !== 2'd0) begin
      errors++;
      $display("FAIL frame_clr_idx: tap_idx=%0d required 0", tap_idx);
    end
    @(posedge clk); #1;
    send_frame(32'h8000, 32'h8000, 32'h8000, 32'h8000);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_tap(32'h8000); send_tap(32'h8000);
    @(negedge clk);
    checks++;
    if (tap_idx !== 2'd2) begin
      errors++;
      $display("FAIL mid_idx: tap_idx=%0d required 2", tap_idx);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_acc = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tap_idx !== 2'd0 || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_frame: tap_idx=%0d y_valid=%b required 0/0", tap_idx, y_valid);
      end
      @(posedge clk); #1;
    end
    y_ready = 1'b0;
    send_frame(32'h8000, 32'h8000, 32'h8000, 32'h8000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    y_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0 || y_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_hold: y_valid=%b y_data=%h required 0/0000", y_valid, y_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_frame_clr();
    test_reset_mid();
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
